sync_stage_sequencer: RTL and testbench

SYNC_STAGE_SEQUENCER -- requirements
Module: sync_stage_sequencer

---
 rtl/asyn_ctl_pkg.sv | 47 ++++
 rtl/opcode_class_decode.sv | 22 ++
 rtl/sync_stage_sequencer.sv | 119 +++++++++++
 tb/tb_sync_stage_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asyn_ctl_pkg.sv
// Shared types and constants for the stage sequencer: FSM states, instruction
// classes and the RV32I major opcodes the sequencer distinguishes.
package asyn_ctl_pkg;

    localparam int unsigned OPCODE_W = 7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_F_REQ,
        ST_F_REL,
        ST_D_REQ,
        ST_D_REL,
        ST_EXE,
        ST_M_REQ,
        ST_M_REL,
        ST_W_REQ,
        ST_W_REL,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [2:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ALU,
        CLS_ILLEGAL
    } instr_class_t;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

    // States in which the sequencer waits on an external ack and the timer runs.
    function automatic logic is_handshake(input state_t s);
        return (s == ST_F_REQ) || (s == ST_F_REL) || (s == ST_D_REQ) ||
               (s == ST_D_REL) || (s == ST_M_REQ) || (s == ST_M_REL) ||
               (s == ST_W_REQ) || (s == ST_W_REL);
    endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Maps an RV32I major opcode onto the instruction class that selects the
// memory / writeback path through the sequencer.
module opcode_class_decode
    import asyn_ctl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output instr_class_t        instr_class_c
);

    always_comb begin
        instr_class_c = CLS_ILLEGAL;
        case (opcode)
            OP_LOAD:   instr_class_c = CLS_LOAD;
            OP_STORE:  instr_class_c = CLS_STORE;
            OP_BRANCH: instr_class_c = CLS_BRANCH;
            OP_OP, OP_OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
                       instr_class_c = CLS_ALU;
            default:   instr_class_c = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/sync_stage_sequencer.sv
// Issues four-phase handshakes to fetch, decode/GPR, memory and writeback units
// for one instruction at a time, with a per-state watchdog into a sticky error.
module sync_stage_sequencer
    import asyn_ctl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                ack_fetch,
    input  logic                ack_dec,
    input  logic                ack_gpr,
    input  logic                ack_mem,
    input  logic                ack_wb,
    output logic                req1,
    output logic                req2_1,
    output logic                req2_2,
    output logic                req3,
    output logic                req4,
    output logic                busy,
    output logic                instr_done,
    output logic                illegal,
    output logic                err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    tmr;
    logic [OPCODE_W-1:0] opcode_q;
    logic                dec_seen;
    logic                gpr_seen;
    logic                dec_hit;
    logic                gpr_hit;
    logic                in_fork;
    instr_class_t        op_class;

    opcode_class_decode u_decode (
        .opcode        (opcode_q),
        .instr_class_c (op_class)
    );

    // A fork ack counts once it has been sampled high, even if it drops later.
    assign dec_hit = ack_dec | dec_seen;
    assign gpr_hit = ack_gpr | gpr_seen;
    assign in_fork = (state == ST_D_REQ) && (state_nxt == ST_D_REQ);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (run)                   state_nxt = ST_F_REQ;
            ST_F_REQ: if (ack_fetch)             state_nxt = ST_F_REL;
            ST_F_REL: if (!ack_fetch)            state_nxt = ST_D_REQ;
            ST_D_REQ: if (dec_hit && gpr_hit)    state_nxt = ST_D_REL;
            ST_D_REL: if (!ack_dec && !ack_gpr)  state_nxt = ST_EXE;
            ST_EXE: begin
                case (op_class)
                    CLS_LOAD, CLS_STORE: state_nxt = ST_M_REQ;
                    CLS_ALU:             state_nxt = ST_W_REQ;
                    default:             state_nxt = ST_DONE;
                endcase
            end
            ST_M_REQ: if (ack_mem)               state_nxt = ST_M_REL;
            ST_M_REL: if (!ack_mem)
                          state_nxt = (op_class == CLS_LOAD) ? ST_W_REQ : ST_DONE;
            ST_W_REQ: if (ack_wb)                state_nxt = ST_W_REL;
            ST_W_REL: if (!ack_wb)               state_nxt = ST_DONE;
            ST_DONE:  state_nxt = run ? ST_F_REQ : ST_IDLE;
            ST_ERR:   state_nxt = ST_ERR;
            default:  state_nxt = ST_IDLE;
        endcase
        // Watchdog only fires when the handshake made no progress this cycle.
        if (is_handshake(state) && (state_nxt == state) && (tmr == TMO_LAST))
            state_nxt = ST_ERR;
    end

    // State, timer, fork tracking and all outputs registered off the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tmr        <= '0;
            opcode_q   <= '0;
            dec_seen   <= 1'b0;
            gpr_seen   <= 1'b0;
            req1       <= 1'b0;
            req2_1     <= 1'b0;
            req2_2     <= 1'b0;
            req3       <= 1'b0;
            req4       <= 1'b0;
            busy       <= 1'b0;
            instr_done <= 1'b0;
            illegal    <= 1'b0;
            err        <= 1'b0;
        end else begin
            state    <= state_nxt;
            tmr      <= ((state_nxt == state) && is_handshake(state)) ? tmr + CNT_W'(1) : '0;
            dec_seen <= in_fork && dec_hit;
            gpr_seen <= in_fork && gpr_hit;
            if ((state == ST_D_REQ) && ack_dec && !dec_seen)
                opcode_q <= opcode;

            req1       <= (state_nxt == ST_F_REQ);
            req2_1     <= (state_nxt == ST_D_REQ) && !((state == ST_D_REQ) && dec_hit);
            req2_2     <= (state_nxt == ST_D_REQ) && !((state == ST_D_REQ) && gpr_hit);
            req3       <= (state_nxt == ST_M_REQ);
            req4       <= (state_nxt == ST_W_REQ);
            busy       <= (state_nxt != ST_IDLE) && (state_nxt != ST_ERR);
            instr_done <= (state_nxt == ST_DONE);
            illegal    <= (state == ST_EXE) && (state_nxt == ST_DONE) &&
                          (op_class == CLS_ILLEGAL);
            err        <= (state_nxt == ST_ERR);
        end
    end

endmodule

// File: tb/tb_sync_stage_sequencer.sv
// Bench for sync_stage_sequencer: parametrised ack responders, per-instruction
// timing predicted from handshake delays, directed corner cases and random runs.
module tb_sync_stage_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [6:0] opcode;
    logic       ack_fetch, ack_dec, ack_gpr, ack_mem, ack_wb;
    logic       req1, req2_1, req2_2, req3, req4;
    logic       busy, instr_done, illegal, err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Unit index: 0 fetch, 1 decode, 2 GPR, 3 memory, 4 writeback.
    int         rdly [5];
    int         fdly [5];
    int         hi   [5];
    int         lo   [5];
    int         rise [5];
    int         fall [5];
    bit         stuck[5];
    logic       ak   [5];
    logic [4:0] prev_rq;
    logic [6:0] cur_op;
    logic [6:0] op_pool [10];

    sync_stage_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .opcode     (opcode),
        .ack_fetch  (ack_fetch),
        .ack_dec    (ack_dec),
        .ack_gpr    (ack_gpr),
        .ack_mem    (ack_mem),
        .ack_wb     (ack_wb),
        .req1       (req1),
        .req2_1     (req2_1),
        .req2_2     (req2_2),
        .req3       (req3),
        .req4       (req4),
        .busy       (busy),
        .instr_done (instr_done),
        .illegal    (illegal),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // 0 LOAD, 1 STORE, 2 BRANCH, 3 ALU, 4 ILLEGAL
    function automatic int model_class(input logic [6:0] op);
        case (op)
            7'b0000011: return 0;
            7'b0100011: return 1;
            7'b1100011: return 2;
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return 3;
            default: return 4;
        endcase
    endfunction

    task automatic set_default();
        for (int u = 0; u < 5; u++) begin
            rdly[u]  = 1;
            fdly[u]  = 0;
            stuck[u] = 1'b0;
        end
    endtask

    task automatic clear_marks();
        for (int u = 0; u < 5; u++) begin
            rise[u] = -1;
            fall[u] = -1;
        end
    endtask

    // One cycle: responders react at the falling edge, monitors check invariants.
    task automatic tick();
        logic [4:0] rq;
        int ncls;
        @(negedge clk);
        cyc++;
        rq = {req4, req3, req2_2, req2_1, req1};
        for (int u = 0; u < 5; u++) begin
            if (rq[u]) begin
                hi[u]++;
                lo[u] = 0;
                if (hi[u] > rdly[u]) ak[u] = 1'b1;
            end else begin
                lo[u]++;
                hi[u] = 0;
                if (lo[u] > fdly[u]) ak[u] = 1'b0;
            end
            if (stuck[u]) ak[u] = 1'b0;
            if (rq[u] && !prev_rq[u] && rise[u] < 0) rise[u] = cyc;
            if (!rq[u] && prev_rq[u] && fall[u] < 0) fall[u] = cyc;
        end
        ack_fetch = ak[0];
        ack_dec   = ak[1];
        ack_gpr   = ak[2];
        ack_mem   = ak[3];
        ack_wb    = ak[4];
        opcode    = ak[1] ? cur_op : 7'($urandom);
        if ((rq[1] && !prev_rq[1]) || (rq[2] && !prev_rq[2]))
            chk("fork_rise", 32'(rq[2:1]), 32'd3);
        ncls = int'(rq[0]) + int'(rq[1] | rq[2]) + int'(rq[3]) + int'(rq[4]);
        chk("one_class", 32'(ncls <= 1), 32'd1);
        if (illegal) chk("illegal_with_done", 32'(instr_done), 32'd1);
        prev_rq = rq;
    endtask

    // Runs one instruction and checks timing/path against delays and opcode class.
    task automatic exec_one(input logic [6:0] op, input bit drop_run);
        int cls, tf, td, tm, tw, lat, t0, dmax;
        bit got;
        cls  = model_class(op);
        cur_op = op;
        clear_marks();
        tf   = rdly[0] + fdly[0] + 2;
        dmax = (rdly[1] > rdly[2]) ? rdly[1] : rdly[2];
        td   = dmax;
        if (rdly[1] + fdly[1] > td) td = rdly[1] + fdly[1];
        if (rdly[2] + fdly[2] > td) td = rdly[2] + fdly[2];
        td   = td + 2;
        tm   = rdly[3] + fdly[3] + 2;
        tw   = rdly[4] + fdly[4] + 2;
        lat  = tf + td + 1 + ((cls <= 1) ? tm : 0) + ((cls == 0 || cls == 3) ? tw : 0);
        got  = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            got = req1;
        end
        if (!got) begin
            chk("fetch_start", 32'd0, 32'd1);
            return;
        end
        t0 = cyc;
        if (drop_run) run = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            got = instr_done;
        end
        chk("done_seen", 32'(got), 32'd1);
        if (!got) return;
        chk("latency", 32'(cyc - t0), 32'(lat));
        chk("illegal", 32'(illegal), 32'(cls == 4));
        chk("decode_start", 32'(rise[1] - t0), 32'(tf));
        chk("dec_fall", 32'(fall[1] - rise[1]), 32'(rdly[1] + 1));
        chk("gpr_fall", 32'(fall[2] - rise[2]), 32'(rdly[2] + 1));
        chk("mem_used", 32'(rise[3] >= 0), 32'(cls <= 1));
        chk("wb_used", 32'(rise[4] >= 0), 32'(cls == 0 || cls == 3));
        if (cls <= 1) chk("mem_start", 32'(rise[3] - t0), 32'(tf + td + 1));
        if (cls == 0 || cls == 3)
            chk("wb_start", 32'(rise[4] - t0), 32'(tf + td + 1 + ((cls == 0) ? tm : 0)));
        if (drop_run) begin
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
            repeat (3) tick();
            chk("stay_idle", 32'({req1, busy}), 32'd0);
        end
    endtask

    initial begin
        int  m0, idx;
        bit  got;
        logic [6:0] op;

        op_pool = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0010011,
                    7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1111111};
        reset = 1'b1;
        run   = 1'b0;
        ack_fetch = 1'b0; ack_dec = 1'b0; ack_gpr = 1'b0; ack_mem = 1'b0; ack_wb = 1'b0;
        opcode  = '0;
        cur_op  = '0;
        prev_rq = '0;
        for (int u = 0; u < 5; u++) begin
            ak[u] = 1'b0;
            hi[u] = 0;
            lo[u] = 0;
        end
        set_default();
        clear_marks();

        // Reset state
        repeat (3) tick();
        chk("reset_reqs", 32'({req1, req2_1, req2_2, req3, req4}), 32'd0);
        chk("reset_flags", 32'({busy, instr_done, illegal, err}), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_no_run", 32'({req1, busy}), 32'd0);

        // ALU with one-cycle responders, then LOAD, STORE, illegal
        run = 1'b1;
        exec_one(7'b0110011, 1'b0);
        exec_one(7'b0000011, 1'b0);
        exec_one(7'b0100011, 1'b0);
        exec_one(7'b1111111, 1'b0);

        // GPR ack four cycles later than decode ack
        rdly[2] = 5;
        exec_one(7'b0010011, 1'b0);
        set_default();

        // Random delays and opcodes
        for (int k = 0; k < 40; k++) begin
            for (int u = 0; u < 5; u++) begin
                rdly[u] = int'($urandom_range(1, 4));
                fdly[u] = int'($urandom_range(0, 3));
            end
            idx = int'($urandom_range(0, 12));
            op  = (idx < 10) ? op_pool[idx] : 7'($urandom);
            exec_one(op, 1'b0);
        end
        set_default();

        // Reset while W_REQ holds with ack_wb high
        cur_op = 7'b0110011;
        clear_marks();
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            tick();
            got = req4 && ack_wb;
        end
        chk("wb_ack_reached", 32'(got), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_reqs", 32'({req1, req2_1, req2_2, req3, req4}), 32'd0);
        chk("midrst_flags", 32'({busy, instr_done, illegal, err}), 32'd0);
        reset = 1'b0;

        // run dropped mid-instruction: instruction still retires, then idle
        exec_one(7'b0110011, 1'b1);

        // Memory ack stuck low -> watchdog
        run = 1'b1;
        stuck[3] = 1'b1;
        cur_op = 7'b0000011;
        clear_marks();
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            tick();
            got = (rise[3] >= 0);
        end
        chk("mem_req_reached", 32'(got), 32'd1);
        m0 = rise[3];
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            got = err;
        end
        chk("err_seen", 32'(got), 32'd1);
        chk("err_latency", 32'(cyc - m0), 32'd7);
        repeat (3) begin
            tick();
            chk("err_reqs", 32'({req1, req2_1, req2_2, req3, req4}), 32'd0);
            chk("err_state", 32'({err, busy}), 32'd2);
        end
        reset = 1'b1;
        tick();
        chk("err_cleared", 32'({err, busy}), 32'd0);
        reset = 1'b0;
        stuck[3] = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
